pong_game_ctrl: RTL

Match sequencer for the pong display datapath. Generates the movement-update strobe that paces the ball and paddle logic. Runs the serve / play / point / game-over state machine from wall-miss events and keeps both players' scores. Sits between the board buttons and the image/object logic; the object logic moves only on move_tick and re-centres the ball on ball_reset.

---
 rtl/pong_pkg.sv | 19 +
 rtl/pong_tick_gen.sv | 34 +++
 rtl/pong_game_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match sequencer: FSM state codes,
// serve-direction encodings and the default update-tick divider.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_POINT    = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam int DEF_TICK_DIV = 500000;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running programmable-period counter; o_tick is high in the last
// count of each period. A new i_period is taken only at the wrap.
module pong_tick_gen #(
    parameter int CNT_W        = 19,
    parameter int RESET_PERIOD = 500000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period_q;
    logic             w_last;

    assign w_last = (r_count == r_period_q - CNT_W'(1));
    assign o_tick = w_last;

    // Latching the period at the wrap keeps a mid-period change from
    // truncating or overshooting the period already in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= '0;
            r_period_q <= CNT_W'(RESET_PERIOD);
        end else if (w_last) begin
            r_count    <= '0;
            r_period_q <= i_period;
        end else begin
            r_count    <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: start-button edge detect, update-tick pacing and the
// serve/play/point/game-over FSM with scores. PONG_SPEEDUP_EN shortens the tick
// period every fourth paddle hit.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int POINT_PAUSE = 100,
    parameter int WIN_SCORE   = 11,
    parameter int SCORE_W     = 4
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               miss_left,
    input  logic               miss_right,
    input  logic               paddle_hit,
    output logic               move_tick,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam int CNT_W   = $clog2(TICK_DIV + 1);
    localparam int PAUSE_W = (POINT_PAUSE > 1) ? $clog2(POINT_PAUSE) : 1;

    logic               r_sync1, r_sync2, r_sync3;
    logic               w_start_rise;
    logic               w_tick;
    logic [CNT_W-1:0]   w_period;
    state_t             r_state;
    logic [SCORE_W-1:0] r_score_l, r_score_r;
    logic [SCORE_W-1:0] w_score_l_inc, w_score_r_inc;
    logic [PAUSE_W-1:0] r_pause_cnt;
    logic               r_serve_dir;
    logic               r_ball_reset;
    logic               r_game_over;

    // btn_start is asynchronous: two flops settle it, the third remembers the
    // previous level so a held button yields a single pulse.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= btn_start;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_start_rise = r_sync2 & ~r_sync3;

`ifdef PONG_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_STEP  = CNT_W'(TICK_DIV / 16);
    localparam logic [CNT_W-1:0] PERIOD_FLOOR = CNT_W'(TICK_DIV / 2);

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_next;
    logic [1:0]       r_hit_cnt;

    assign w_period_next = (r_period >= PERIOD_FLOOR + PERIOD_STEP) ?
                           r_period - PERIOD_STEP : PERIOD_FLOOR;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_period  <= CNT_W'(TICK_DIV);
            r_hit_cnt <= '0;
        end else if (r_state == ST_SERVE) begin
            r_period  <= CNT_W'(TICK_DIV);
            r_hit_cnt <= '0;
        end else if (r_state == ST_PLAY && w_tick && paddle_hit) begin
            r_hit_cnt <= r_hit_cnt + 2'd1;
            if (r_hit_cnt == 2'd3)
                r_period <= w_period_next;
        end
    end

    assign w_period = r_period;
`else
    logic w_unused_hit;

    assign w_unused_hit = paddle_hit;
    assign w_period     = CNT_W'(TICK_DIV);
`endif

    pong_tick_gen #(
        .CNT_W        (CNT_W),
        .RESET_PERIOD (TICK_DIV)
    ) u_tick_gen (
        .i_clk    (CLK100MHZ),
        .i_rst    (reset),
        .i_period (w_period),
        .o_tick   (w_tick)
    );

    assign w_score_l_inc = r_score_l + SCORE_W'(1);
    assign w_score_r_inc = r_score_r + SCORE_W'(1);

    // NOTE: all FSM state and outputs use <= so every branch reads the values
    // from before this edge, independent of statement order.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_pause_cnt  <= '0;
            r_serve_dir  <= SERVE_RIGHT;
            r_ball_reset <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_ball_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_score_l <= '0;
                    r_score_r <= '0;
                    if (w_start_rise) begin
                        r_state      <= ST_SERVE;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_SERVE: r_state <= ST_PLAY;
                ST_PLAY: begin
                    if (w_start_rise) begin
                        r_state <= ST_PAUSE;
                    end else if (w_tick) begin
                        if (miss_left && miss_right) begin
                            r_state <= ST_POINT;
                        end else if (miss_left) begin
                            r_score_r   <= w_score_r_inc;
                            r_serve_dir <= SERVE_LEFT;
                            r_game_over <= (w_score_r_inc == SCORE_W'(WIN_SCORE));
                            r_state     <= (w_score_r_inc == SCORE_W'(WIN_SCORE)) ?
                                           ST_GAMEOVER : ST_POINT;
                        end else if (miss_right) begin
                            r_score_l   <= w_score_l_inc;
                            r_serve_dir <= SERVE_RIGHT;
                            r_game_over <= (w_score_l_inc == SCORE_W'(WIN_SCORE));
                            r_state     <= (w_score_l_inc == SCORE_W'(WIN_SCORE)) ?
                                           ST_GAMEOVER : ST_POINT;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_start_rise)
                        r_state <= ST_PLAY;
                end
                ST_POINT: begin
                    if (w_tick) begin
                        if (r_pause_cnt == PAUSE_W'(POINT_PAUSE - 1)) begin
                            r_pause_cnt  <= '0;
                            r_state      <= ST_SERVE;
                            r_ball_reset <= 1'b1;
                        end else begin
                            r_pause_cnt  <= r_pause_cnt + PAUSE_W'(1);
                        end
                    end
                end
                ST_GAMEOVER: begin
                    if (w_start_rise) begin
                        r_score_l    <= '0;
                        r_score_r    <= '0;
                        r_game_over  <= 1'b0;
                        r_state      <= ST_SERVE;
                        r_ball_reset <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign move_tick  = w_tick && (r_state == ST_PLAY);
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign state      = r_state;
    assign game_over  = r_game_over;

endmodule
